// File: rtl/add_sub_unit_pkg.sv
// Shared project types: reservation-station entry, data word and tag constants.
package add_sub_unit_pkg;

  localparam int TAG_W = 8;
  localparam logic [TAG_W-1:0] TAG_READY = '0;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] alu1;
    logic [TAG_W-1:0] alu2;
    word_t            value1;
    word_t            value2;
  } ReservationStation;

endpackage

// File: rtl/add_sub_delay.sv
// LATENCY-deep valid/data delay line; cancel kills any valid advancing, data holds
// in each stage until a surviving valid loads it, so the last stage acts as the result hold.
module add_sub_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  input  logic         cancel_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][W-1:0] dat_q, dat_d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic         in_v;
    logic [W-1:0] in_d;
    if (k == 0) begin : g_head
      assign in_v = vld_i;
      assign in_d = data_i;
    end else begin : g_body
      assign in_v = vld_q[k-1];
      assign in_d = dat_q[k-1];
    end
    assign vld_d[k] = in_v & ~cancel_i;
    assign dat_d[k] = vld_d[k] ? in_d : dat_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = dat_q[DEPTH-1];

endmodule

// File: rtl/add_sub_unit.sv
// Reservation-station add/subtract unit with one result pulse per issued entry.
// Optional signed-overflow output enabled by defining ADD_SUB_OVF_EN.
module add_sub_unit
  import add_sub_unit_pkg::*;
#(
  parameter int IS_SUB  = 0,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              RSTN_N,
  input  ReservationStation rstation,
  output word_t             result,
  output logic              result_available
`ifdef ADD_SUB_OVF_EN
  ,output logic             overflow
`endif
);

`ifdef ADD_SUB_OVF_EN
  localparam int W = 33;
`else
  localparam int W = 32;
`endif

  logic         pending_q, pending_d;
  logic         capture;
  word_t        sum;
  logic [W-1:0] dly_in, dly_out;

  // Pending blocks re-capture of the same entry until busy is seen low.
  always_comb begin
    capture   = rstation.busy && (rstation.alu1 == TAG_READY) &&
                (rstation.alu2 == TAG_READY) && !pending_q;
    pending_d = rstation.busy ? (pending_q | capture) : 1'b0;
  end

  always_ff @(posedge clk or negedge RSTN_N) begin
    if (!RSTN_N) pending_q <= 1'b0;
    else         pending_q <= pending_d;
  end

  always_comb begin
    if (IS_SUB != 0) sum = rstation.value1 - rstation.value2;
    else             sum = rstation.value1 + rstation.value2;
  end

`ifdef ADD_SUB_OVF_EN
  logic ovf;
  always_comb begin
    if (IS_SUB != 0)
      ovf = (rstation.value1[31] != rstation.value2[31]) && (sum[31] != rstation.value1[31]);
    else
      ovf = (rstation.value1[31] == rstation.value2[31]) && (sum[31] != rstation.value1[31]);
  end
  assign dly_in   = {ovf, sum};
  assign overflow = dly_out[32];
`else
  assign dly_in   = sum;
`endif

  add_sub_delay #(.DEPTH(LATENCY), .W(W)) u_delay (
    .clk      (clk),
    .rst_n    (RSTN_N),
    .vld_i    (capture),
    .data_i   (dly_in),
    .cancel_i (~rstation.busy),
    .vld_o    (result_available),
    .data_o   (dly_out)
  );

  assign result = dly_out[31:0];

endmodule

// File: tb/tb_add_sub_unit.sv
// Directed bench: an adder (L=1), a subtractor (L=1) and an adder (L=3) share one stimulus.
module tb_add_sub_unit;
  import add_sub_unit_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  ReservationStation rs;
  word_t res_a, res_s, res_3;
  logic  av_a, av_s, av_3;
`ifdef ADD_SUB_OVF_EN
  logic  ov_a, ov_s, ov_3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  add_sub_unit #(.IS_SUB(0), .LATENCY(1)) dut_add (
    .clk(clk), .RSTN_N(rstn), .rstation(rs), .result(res_a), .result_available(av_a)
`ifdef ADD_SUB_OVF_EN
    , .overflow(ov_a)
`endif
  );
  add_sub_unit #(.IS_SUB(1), .LATENCY(1)) dut_sub (
    .clk(clk), .RSTN_N(rstn), .rstation(rs), .result(res_s), .result_available(av_s)
`ifdef ADD_SUB_OVF_EN
    , .overflow(ov_s)
`endif
  );
  add_sub_unit #(.IS_SUB(0), .LATENCY(3)) dut_l3 (
    .clk(clk), .RSTN_N(rstn), .rstation(rs), .result(res_3), .result_available(av_3)
`ifdef ADD_SUB_OVF_EN
    , .overflow(ov_3)
`endif
  );

  typedef struct {
    word_t v1, v2, add, sub;
    logic  oa, os;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic busy, input logic [7:0] t1, input word_t v1, input word_t v2);
    rs.busy = busy; rs.alu1 = t1; rs.alu2 = 8'd0; rs.value1 = v1; rs.value2 = v2;
  endtask

  task automatic count_pulses(input int edges, output int ca, output int c3);
    ca = 0; c3 = 0;
    for (int i = 0; i < edges; i++) begin
      tick();
      if (av_a) ca++;
      if (av_3) c3++;
    end
  endtask

  int ca, c3;

  initial begin
    vecs[0] = '{32'd5,        32'd7,  32'd12,       32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[1] = '{32'd3,        32'd5,  32'd8,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'd1,  32'd0,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h80000000, 32'd1,  32'h80000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h7FFFFFFF, 32'd1,  32'h80000000, 32'h7FFFFFFE, 1'b1, 1'b0};
    vecs[5] = '{32'd0,        32'd0,  32'd0,        32'd0,        1'b0, 1'b0};
    vecs[6] = '{32'd10,       32'd20, 32'd30,       32'hFFFFFFF6, 1'b0, 1'b0};

    rstn = 1'b0;
    rs   = '0;
    #12;
    chk("reset_res_add", res_a, 32'd0);
    chk("reset_av_add", {31'd0, av_a}, 32'd0);
    chk("reset_res_l3", res_3, 32'd0);
    chk("reset_av_l3", {31'd0, av_3}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'd0, vecs[i].v1, vecs[i].v2);
      tick();
      chk($sformatf("v%0d_av_add", i), {31'd0, av_a}, 32'd1);
      chk($sformatf("v%0d_res_add", i), res_a, vecs[i].add);
      chk($sformatf("v%0d_av_sub", i), {31'd0, av_s}, 32'd1);
      chk($sformatf("v%0d_res_sub", i), res_s, vecs[i].sub);
      chk($sformatf("v%0d_av_l3_e0", i), {31'd0, av_3}, 32'd0);
`ifdef ADD_SUB_OVF_EN
      chk($sformatf("v%0d_ovf_add", i), {31'd0, ov_a}, {31'd0, vecs[i].oa});
      chk($sformatf("v%0d_ovf_sub", i), {31'd0, ov_s}, {31'd0, vecs[i].os});
`endif
      tick();
      chk($sformatf("v%0d_av_add_drop", i), {31'd0, av_a}, 32'd0);
      chk($sformatf("v%0d_av_l3_e1", i), {31'd0, av_3}, 32'd0);
      tick();
      chk($sformatf("v%0d_av_l3", i), {31'd0, av_3}, 32'd1);
      chk($sformatf("v%0d_res_l3", i), res_3, vecs[i].add);
      rs.busy = 1'b0;
      tick();
      chk($sformatf("v%0d_av_l3_drop", i), {31'd0, av_3}, 32'd0);
      chk($sformatf("v%0d_hold_add", i), res_a, vecs[i].add);
      chk($sformatf("v%0d_hold_l3", i), res_3, vecs[i].add);
    end

    // busy held six cycles: one pulse only, then reissue after a one-cycle drop
    drive(1'b1, 8'd0, 32'd1, 32'd2);
    count_pulses(6, ca, c3);
    chk("hold_pulses_add", ca, 32'd1);
    chk("hold_pulses_l3", c3, 32'd1);
    chk("hold_res_add", res_a, 32'd3);
    rs.busy = 1'b0;
    tick();
    drive(1'b1, 8'd0, 32'd10, 32'd20);
    tick();
    chk("reissue_av", {31'd0, av_a}, 32'd1);
    chk("reissue_res", res_a, 32'd30);
    rs.busy = 1'b0;
    tick(); tick();

    // operand tag not ready for four cycles, then ready
    drive(1'b1, 8'd3, 32'd1, 32'd1);
    count_pulses(4, ca, c3);
    chk("tag_wait_pulses", ca, 32'd0);
    rs.alu1 = 8'd0;
    tick();
    chk("tag_ready_av", {31'd0, av_a}, 32'd1);
    chk("tag_ready_res", res_a, 32'd2);
    rs.busy = 1'b0;
    tick(); tick(); tick();

    // reset one cycle after capture discards the in-flight L=3 result
    drive(1'b1, 8'd0, 32'd9, 32'd9);
    tick();
    rstn = 1'b0;
    rs.busy = 1'b0;
    #1;
    chk("rst_mid_res_l3", res_3, 32'd0);
    chk("rst_mid_av_l3", {31'd0, av_3}, 32'd0);
    chk("rst_mid_res_add", res_a, 32'd0);
    tick();
    rstn = 1'b1;
    count_pulses(4, ca, c3);
    chk("rst_after_pulses_l3", c3, 32'd0);
    chk("rst_after_res_l3", res_3, 32'd0);

    // busy dropped mid-flight cancels the L=3 operation
    drive(1'b1, 8'd0, 32'd4, 32'd4);
    tick();
    chk("cancel_add_res", res_a, 32'd8);
    rs.busy = 1'b0;
    count_pulses(4, ca, c3);
    chk("cancel_pulses_l3", c3, 32'd0);
    chk("cancel_res_l3", res_3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
